load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles to wait for a RAM response before faulting (range 2..255).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_valid  input  1  the execute stage presents a request.
REQ-005 SHALL have port o_ready  output  1  the unit accepts a request this cycle.
REQ-006 SHALL have port i_load  input  1  the request is a load.
REQ-007 SHALL have port i_store  input  1  the request is a store (i_load and i_store together: load wins).
REQ-008 SHALL have port i_funct3  input  3  RISC-V width code.
REQ-009 SHALL have port i_addr  input  32  byte address, or ALU result for non-memory operations.
REQ-010 SHALL have port i_wdata  input  32  store data (rs2).
REQ-011 SHALL have port i_rd  input  5  destination register tag.
REQ-012 SHALL have port o_valid  output  1  the result is presented to writeback.
REQ-013 SHALL have port i_wb_ready  input  1  writeback accepts the result.
REQ-014 SHALL have port o_result  output  32  load data or pass-through value.
REQ-015 SHALL have port o_rd  output  5  destination tag carried with the result.
REQ-016 SHALL have port o_exc_misaligned  output  1  misaligned-access exception, qualified by o_valid.
REQ-017 SHALL have port o_exc_access  output  1  access-fault exception, qualified by o_valid.
REQ-018 SHALL have port o_mem_wr_en  output  1  RAM write enable.
REQ-019 SHALL have port o_mem_sel  output  4  RAM byte-lane enables.
REQ-020 SHALL have port o_mem_addr  output  32  RAM address, always word aligned ({addr[31:2],2'b00}).
REQ-021 SHALL have port o_mem_wdata  output  32  lane-replicated store data.
REQ-022 SHALL have port i_mem_rdata  input  32  RAM read word.
REQ-023 SHALL have port o_mem_ready  output  1  RAM request strobe.
REQ-024 SHALL have port i_mem_valid  input  1  RAM response valid.
REQ-025 SHALL have port i_mem_error  input  1  RAM error response.

Function
REQ-026 SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE; o_ready=1 only in IDLE; a request is accepted when i_valid and o_ready are both high.
REQ-027 SHALL, on acceptance, register funct3, addr[1:0], rd, the load/store flags and i_addr for the duration of the transaction.
REQ-028 SHALL send a request that is neither load nor store directly to RESP, with o_result = i_addr and no RAM activity (1-cycle latency).
REQ-029 SHALL flag a request as misaligned when it is a halfword (001/101) with addr[0]=1, or a word (010) with addr[1:0]!=0; such a request goes directly to RESP with o_exc_misaligned=1, o_result=0, and no RAM strobe.
REQ-030 SHALL treat load funct3 011/110/111 and store funct3 >=011 as illegal; an illegal request goes directly to RESP with o_exc_access=1, o_result=0, and no RAM strobe.
REQ-031 SHALL, in ACCESS, hold o_mem_ready=1 and keep address, sel, wdata and wr_en stable until i_mem_valid or i_mem_error is sampled high.
REQ-032 SHALL drive o_mem_sel as 0001<<addr[1:0] for SB, 0011<<addr[1:0] for SH, 1111 for SW, and 1111 for all loads.
REQ-033 SHALL drive o_mem_wdata as {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH, and wdata for SW.
REQ-034 SHALL register the load result on the response cycle: select the lane i_mem_rdata >> (8*addr[1:0]); LB/LH sign-extend, LBU/LHU zero-extend, LW pass the word through; stores return 0.
REQ-035 SHALL, when i_mem_error=1 (even if i_mem_valid=1 in the same cycle), go to RESP with o_exc_access=1 and o_result=0.
REQ-036 SHALL count cycles in ACCESS with an 8-bit counter; after TIMEOUT cycles with no response, drop o_mem_ready and go to RESP with o_exc_access=1.
REQ-037 SHALL hold o_valid=1 and all result fields stable in RESP until i_wb_ready is high, then return to IDLE; a new request is not accepted in that same cycle.
REQ-038 SHALL keep o_mem_wr_en=0 and o_mem_ready=0 outside ACCESS.

Reset
REQ-039 SHALL, on asserting rst_n low, immediately enter IDLE and clear to 0: o_valid, o_mem_ready, o_mem_wr_en, o_mem_sel, o_exc_*, o_result, o_rd, and the timeout counter; o_ready goes to 1 once rst_n is released.
REQ-040 SHALL abandon any transaction in progress when reset occurs mid-transaction, with no result issued afterwards.

Structure
REQ-041 SHALL take FSM state encodings, the funct3 width codes (LB=000, LH=001, LW=010, LBU=100, LHU=101), and the default TIMEOUT from the shared core package.
REQ-042 SHALL use one sub-module, load_align, as combinational lane-extract/extend logic instantiated by load_store_unit.

Verification
REQ-043 SHALL verify: SB addr=0x1003, wdata=0x000000AB -> o_mem_addr=0x1000, sel=1000, wdata=0xABABABAB, wr_en=1.
REQ-044 SHALL verify: LB addr=0x1001 with RAM word 0x1234_80FF -> o_result=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-045 SHALL verify: LW addr=0x1002 -> o_exc_misaligned=1, o_mem_ready never asserted, o_valid one cycle after acceptance.
REQ-046 SHALL verify: LH to a RAM that answers i_mem_error=1 -> o_exc_access=1, o_result=0.
REQ-047 SHALL verify: a RAM that never responds with TIMEOUT=4 -> o_mem_ready held for 4 cycles, then o_exc_access=1.
REQ-048 SHALL verify: i_wb_ready held low for 3 cycles in RESP -> o_valid and o_result stable and o_ready=0 throughout; rst_n pulsed in ACCESS -> IDLE with no o_valid.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared core definitions for the load/store unit: FSM encodings, RISC-V
// width codes and the small decode helpers used on request acceptance.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  // Halfword codes (001/101) need addr[0]=0; only LW/SW (010) need full alignment.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] offset);
    return ((funct3[1:0] == 2'b01) && offset[0]) ||
           ((funct3 == F3_LW) && (offset != 2'b00));
  endfunction

  function automatic logic is_illegal(input logic load, input logic [2:0] funct3);
    if (load)
      return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    return (funct3 >= 3'b011);
  endfunction

  function automatic logic [3:0] lane_sel(input logic store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
    if (!store) return 4'b1111;
    case (funct3[1:0])
      2'b00:   return 4'b0001 << offset;
      2'b01:   return 4'b0011 << offset;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] funct3,
                                             input logic [31:0] wdata);
    case (funct3[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed lane from a RAM read word and sign/zero extends it
// according to the load width code.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] lane;

  always_comb begin
    lane = rdata >> {offset, 3'b000};
    data = 32'd0;
    case (funct3)
      F3_LB:   data = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   data = {{16{lane[15]}}, lane[15:0]};
      F3_LW:   data = lane;
      F3_LBU:  data = {24'd0, lane[7:0]};
      F3_LHU:  data = {16'd0, lane[15:0]};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between execute and writeback: decodes
// the request, drives one RAM transaction with timeout, aligns load data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd,
  output logic        o_valid,
  input  logic        i_wb_ready,
  output logic [31:0] o_result,
  output logic [4:0]  o_rd,
  output logic        o_exc_misaligned,
  output logic        o_exc_access,
  output logic        o_mem_wr_en,
  output logic [3:0]  o_mem_sel,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_mem_ready,
  input  logic        i_mem_valid,
  input  logic        i_mem_error
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  lsu_state_t  state;
  logic [7:0]  wait_cnt;
  logic        is_load_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] load_data;

  logic accept;
  logic req_load;
  logic req_store;
  logic req_illegal;
  logic req_misaligned;

  assign accept         = (state == ST_IDLE) && i_valid && o_ready;
  assign req_load       = i_load;
  assign req_store      = i_store && !i_load;
  assign req_illegal    = is_illegal(req_load, i_funct3);
  assign req_misaligned = is_misaligned(i_funct3, i_addr[1:0]);

  assign o_mem_addr = {addr_q[31:2], 2'b00};

  load_align u_load_align (
    .rdata  (i_mem_rdata),
    .offset (addr_q[1:0]),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  // Transaction payload: captured once at acceptance, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      funct3_q    <= i_funct3;
      addr_q      <= i_addr;
      o_mem_wdata <= lane_wdata(i_funct3, i_wdata);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      o_ready          <= 1'b0;
      o_valid          <= 1'b0;
      o_mem_ready      <= 1'b0;
      o_mem_wr_en      <= 1'b0;
      o_mem_sel        <= 4'd0;
      o_exc_misaligned <= 1'b0;
      o_exc_access     <= 1'b0;
      o_result         <= 32'd0;
      o_rd             <= 5'd0;
      wait_cnt         <= 8'd0;
      is_load_q        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            o_ready          <= 1'b0;
            o_rd             <= i_rd;
            is_load_q        <= req_load;
            o_exc_misaligned <= 1'b0;
            o_exc_access     <= 1'b0;
            o_result         <= 32'd0;
            if (!req_load && !req_store) begin
              state    <= ST_RESP;
              o_valid  <= 1'b1;
              o_result <= i_addr;
            end else if (req_illegal) begin
              state        <= ST_RESP;
              o_valid      <= 1'b1;
              o_exc_access <= 1'b1;
            end else if (req_misaligned) begin
              state            <= ST_RESP;
              o_valid          <= 1'b1;
              o_exc_misaligned <= 1'b1;
            end else begin
              state       <= ST_ACCESS;
              o_mem_ready <= 1'b1;
              o_mem_wr_en <= req_store;
              o_mem_sel   <= lane_sel(req_store, i_funct3, i_addr[1:0]);
              wait_cnt    <= 8'd0;
            end
          end else begin
            o_ready <= 1'b1;
          end
        end

        ST_ACCESS: begin
          // Error wins over a simultaneous valid; silence past the budget is a fault.
          if (i_mem_error || i_mem_valid || (wait_cnt == TIMEOUT_LAST)) begin
            state        <= ST_RESP;
            o_valid      <= 1'b1;
            o_mem_ready  <= 1'b0;
            o_mem_wr_en  <= 1'b0;
            o_mem_sel    <= 4'd0;
            wait_cnt     <= 8'd0;
            o_exc_access <= i_mem_error || !i_mem_valid;
            o_result     <= (!i_mem_error && i_mem_valid && is_load_q) ? load_data : 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        ST_RESP: begin
          if (i_wb_ready) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end

        default: begin
          state       <= ST_IDLE;
          o_valid     <= 1'b0;
          o_mem_ready <= 1'b0;
          o_mem_wr_en <= 1'b0;
          o_ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scenario bench for load_store_unit with a behavioural RAM responder and an
// expected-result queue filled at issue and drained at writeback.
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_load = 1'b0;
  logic        i_store = 1'b0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_wdata = 32'd0;
  logic [4:0]  i_rd = 5'd0;
  logic        o_valid;
  logic        i_wb_ready = 1'b1;
  logic [31:0] o_result;
  logic [4:0]  o_rd;
  logic        o_exc_misaligned;
  logic        o_exc_access;
  logic        o_mem_wr_en;
  logic [3:0]  o_mem_sel;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata = 32'd0;
  logic        o_mem_ready;
  logic        i_mem_valid = 1'b0;
  logic        i_mem_error = 1'b0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_load(i_load), .i_store(i_store), .i_funct3(i_funct3), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_rd(i_rd), .o_valid(o_valid), .i_wb_ready(i_wb_ready),
    .o_result(o_result), .o_rd(o_rd), .o_exc_misaligned(o_exc_misaligned),
    .o_exc_access(o_exc_access), .o_mem_wr_en(o_mem_wr_en), .o_mem_sel(o_mem_sel),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .o_mem_ready(o_mem_ready), .i_mem_valid(i_mem_valid), .i_mem_error(i_mem_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        mis;
    logic        acc;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // RAM responder: 0 = data after ram_lat strobe cycles, 1 = error, 2 = silent, 3 = error+valid.
  int          ram_mode = 0;
  int          ram_lat = 1;
  logic [31:0] ram_word = 32'd0;
  int          strobe_cycles = 0;
  int          strobe_max = 0;
  int          strobe_total = 0;
  logic        stab_err = 1'b0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_sel;
  logic        cap_wr;

  always @(negedge clk) begin
    i_mem_valid = 1'b0;
    i_mem_error = 1'b0;
    if (o_mem_ready) begin
      strobe_cycles++;
      strobe_total++;
      if (strobe_cycles > strobe_max) strobe_max = strobe_cycles;
      if (strobe_cycles == 1) begin
        cap_addr = o_mem_addr; cap_wdata = o_mem_wdata; cap_sel = o_mem_sel; cap_wr = o_mem_wr_en;
      end else if (cap_addr !== o_mem_addr || cap_wdata !== o_mem_wdata ||
                   cap_sel !== o_mem_sel || cap_wr !== o_mem_wr_en) begin
        stab_err = 1'b1;
      end
      if (ram_mode != 2 && strobe_cycles >= ram_lat) begin
        i_mem_rdata = ram_word;
        if (ram_mode == 1 || ram_mode == 3) i_mem_error = 1'b1;
        if (ram_mode == 0 || ram_mode == 3) i_mem_valid = 1'b1;
      end
    end else begin
      strobe_cycles = 0;
    end
  end

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic [31:0] e_res,
                       input logic e_mis, input logic e_acc);
    int waited = 0;
    exp_t e;
    while (!o_ready && waited < 50) begin @(negedge clk); waited++; end
    if (!o_ready) begin
      n_vec++; n_err++;
      $display("FAIL issue_ready_timeout o_ready=%0b after %0d cycles, required 1", o_ready, waited);
    end
    strobe_max = 0; strobe_total = 0; stab_err = 1'b0;
    i_valid = 1'b1; i_load = ld; i_store = st; i_funct3 = f3;
    i_addr = addr; i_wdata = wdata; i_rd = rd;
    e.result = e_res; e.rd = rd; e.mis = e_mis; e.acc = e_acc;
    sb.push_back(e);
    @(negedge clk);
    i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
  endtask

  // Waits (bounded) for o_valid, samples the result and pops the matching expectation.
  task automatic collect(output logic [38:0] got, output logic [38:0] want, output int cycles);
    exp_t e;
    cycles = 0;
    while (!o_valid && cycles < 50) begin @(negedge clk); cycles++; end
    got = {o_rd, o_exc_misaligned, o_exc_access, o_result};
    if (sb.size() == 0) begin
      want = '1;
    end else begin
      e = sb.pop_front();
      want = {e.rd, e.mis, e.acc, e.result};
    end
    if (!o_valid) begin
      n_vec++; n_err++;
      $display("FAIL collect_timeout o_valid=0 after %0d cycles, required 1", cycles);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({o_valid, o_mem_ready, o_mem_wr_en, o_mem_sel, o_exc_misaligned, o_exc_access, o_result, o_rd, o_ready} !== 47'd0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b mr=%b we=%b sel=%b em=%b ea=%b res=%h rd=%0d rdy=%b, required all 0",
               o_valid, o_mem_ready, o_mem_wr_en, o_mem_sel, o_exc_misaligned, o_exc_access, o_result, o_rd, o_ready);
    end
    n_vec++;
    if (dut.wait_cnt !== 8'd0) begin n_err++; $display("FAIL reset_counter got %0d required 0", dut.wait_cnt); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b required 1", o_ready); end
  endtask

  task automatic test_store();
    logic [38:0] got, want;
    int cyc;
    ram_mode = 0; ram_lat = 3;
    issue(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 5'd1, 32'd0, 1'b0, 1'b0);
    collect(got, want, cyc);
    n_vec++;
    if ({cap_addr, cap_sel, cap_wdata, cap_wr} !== {32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 1'b1}) begin
      n_err++;
      $display("FAIL sb_bus got addr=%h sel=%b wd=%h we=%b required 00001000 1000 abababab 1", cap_addr, cap_sel, cap_wdata, cap_wr);
    end
    n_vec++; if (stab_err !== 1'b0) begin n_err++; $display("FAIL sb_stable got change=%b required 0", stab_err); end
    n_vec++; if (strobe_max !== 3) begin n_err++; $display("FAIL sb_strobe got %0d cycles required 3", strobe_max); end
    n_vec++; if (got !== want) begin n_err++; $display("FAIL sb_result got %h required %h", got, want); end

    issue(1'b0, 1'b1, 3'b001, 32'h0000_1002, 32'h1234_CDEF, 5'd2, 32'd0, 1'b0, 1'b0);
    collect(got, want, cyc);
    n_vec++;
    if ({cap_addr, cap_sel, cap_wdata, cap_wr} !== {32'h0000_1000, 4'b1100, 32'hCDEF_CDEF, 1'b1}) begin
      n_err++;
      $display("FAIL sh_bus got addr=%h sel=%b wd=%h we=%b required 00001000 1100 cdefcdef 1", cap_addr, cap_sel, cap_wdata, cap_wr);
    end
    n_vec++; if (got !== want) begin n_err++; $display("FAIL sh_result got %h required %h", got, want); end

    issue(1'b0, 1'b1, 3'b010, 32'h0000_2000, 32'hCAFE_F00D, 5'd3, 32'd0, 1'b0, 1'b0);
    collect(got, want, cyc);
    n_vec++;
    if ({cap_sel, cap_wdata, cap_wr} !== {4'b1111, 32'hCAFE_F00D, 1'b1}) begin
      n_err++;
      $display("FAIL sw_bus got sel=%b wd=%h we=%b required 1111 cafef00d 1", cap_sel, cap_wdata, cap_wr);
    end
    n_vec++; if (got !== want) begin n_err++; $display("FAIL sw_result got %h required %h", got, want); end
  endtask

  task automatic test_load();
    logic [38:0] got, want;
    int cyc;
    ram_mode = 0; ram_lat = 1;
    ram_word = 32'h1234_80FF;
    issue(1'b1, 1'b0, 3'b000, 32'h0000_1001, 32'd0, 5'd5, 32'hFFFF_FF80, 1'b0, 1'b0);
    collect(got, want, cyc);
    n_vec++; if (got !== want) begin n_err++; $display("FAIL lb_result got %h required %h", got, want); end
    n_vec++;
    if ({cap_addr, cap_sel, cap_wr} !== {32'h0000_1000, 4'b1111, 1'b0}) begin
      n_err++; $display("FAIL lb_bus got addr=%h sel=%b we=%b required 00001000 1111 0", cap_addr, cap_sel, cap_wr);
    end
    issue(1'b1, 1'b0, 3'b100, 32'h0000_1001, 32'd0, 5'd6, 32'h0000_0080, 1'b0, 1'b0);
    collect(got, want, cyc);
    n_vec++; if (got !== want) begin n_err++; $display("FAIL lbu_result got %h required %h", got, want); end

    ram_word = 32'h8001_1234;
    issue(1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'd0, 5'd7, 32'hFFFF_8001, 1'b0, 1'b0);
    collect(got, want, cyc);
    n_vec++; if (got !== want) begin n_err++; $display("FAIL lh_result got %h required %h", got, want); end
    issue(1'b1, 1'b0, 3'b101, 32'h0000_1002, 32'd0, 5'd8, 32'h0000_8001, 1'b0, 1'b0);
    collect(got, want, cyc);
    n_vec++; if (got !== want) begin n_err++; $display("FAIL lhu_result got %h required %h", got, want); end

    ram_word = 32'hDEAD_BEEF;
    issue(1'b1, 1'b1, 3'b010, 32'h0000_1004, 32'h1111_1111, 5'd9, 32'hDEAD_BEEF, 1'b0, 1'b0);
    collect(got, want, cyc);
    n_vec++; if (got !== want) begin n_err++; $display("FAIL lw_result got %h required %h", got, want); end
    n_vec++; if (cap_wr !== 1'b0) begin n_err++; $display("FAIL load_wins_wr got %b required 0", cap_wr); end
  endtask

  task automatic test_misaligned();
    logic [38:0] got, want;
    int cyc;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'd0, 5'd10, 32'd0, 1'b1, 1'b0);
    collect(got, want, cyc);
    n_vec++; if (got !== want) begin n_err++; $display("FAIL lw_mis_result got %h required %h", got, want); end
    n_vec++; if (cyc !== 0) begin n_err++; $display("FAIL lw_mis_latency got %0d extra cycles required 0", cyc); end
    n_vec++; if (strobe_total !== 0) begin n_err++; $display("FAIL lw_mis_strobe got %0d strobe cycles required 0", strobe_total); end
    issue(1'b0, 1'b1, 3'b001, 32'h0000_1001, 32'hFFFF_FFFF, 5'd11, 32'd0, 1'b1, 1'b0);
    collect(got, want, cyc);
    n_vec++; if (got !== want) begin n_err++; $display("FAIL sh_mis_result got %h required %h", got, want); end
    n_vec++; if (strobe_total !== 0) begin n_err++; $display("FAIL sh_mis_strobe got %0d required 0", strobe_total); end
  endtask

  task automatic test_illegal_passthrough();
    logic [38:0] got, want;
    int cyc;
    issue(1'b1, 1'b0, 3'b011, 32'h0000_1000, 32'd0, 5'd12, 32'd0, 1'b0, 1'b1);
    collect(got, want, cyc);
    n_vec++; if (got !== want) begin n_err++; $display("FAIL ld_illegal got %h required %h", got, want); end
    issue(1'b0, 1'b1, 3'b100, 32'h0000_1000, 32'd0, 5'd13, 32'd0, 1'b0, 1'b1);
    collect(got, want, cyc);
    n_vec++; if (got !== want) begin n_err++; $display("FAIL st_illegal got %h required %h", got, want); end
    n_vec++; if (strobe_total !== 0) begin n_err++; $display("FAIL illegal_strobe got %0d required 0", strobe_total); end
    issue(1'b0, 1'b0, 3'b010, 32'h7654_3211, 32'd0, 5'd14, 32'h7654_3211, 1'b0, 1'b0);
    collect(got, want, cyc);
    n_vec++; if (got !== want) begin n_err++; $display("FAIL passthru got %h required %h", got, want); end
    n_vec++; if (cyc !== 0 || strobe_total !== 0) begin n_err++; $display("FAIL passthru_latency got %0d/%0d required 0/0", cyc, strobe_total); end
  endtask

  task automatic test_mem_error();
    logic [38:0] got, want;
    int cyc;
    ram_word = 32'hFFFF_FFFF;
    ram_mode = 1; ram_lat = 2;
    issue(1'b1, 1'b0, 3'b001, 32'h0000_3000, 32'd0, 5'd15, 32'd0, 1'b0, 1'b1);
    collect(got, want, cyc);
    n_vec++; if (got !== want) begin n_err++; $display("FAIL lh_error got %h required %h", got, want); end
    ram_mode = 3; ram_lat = 1;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_3004, 32'd0, 5'd16, 32'd0, 1'b0, 1'b1);
    collect(got, want, cyc);
    n_vec++; if (got !== want) begin n_err++; $display("FAIL err_and_valid got %h required %h", got, want); end
    ram_mode = 0;
  endtask

  task automatic test_timeout();
    logic [38:0] got, want;
    int cyc;
    ram_mode = 2;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'd0, 5'd17, 32'd0, 1'b0, 1'b1);
    collect(got, want, cyc);
    n_vec++; if (strobe_max !== TO) begin n_err++; $display("FAIL timeout_strobe got %0d cycles required %0d", strobe_max, TO); end
    n_vec++; if (got !== want) begin n_err++; $display("FAIL timeout_result got %h required %h", got, want); end
    n_vec++; if (o_mem_ready !== 1'b0) begin n_err++; $display("FAIL timeout_strobe_drop got %b required 0", o_mem_ready); end
    ram_mode = 0;
  endtask

  task automatic test_wb_stall();
    logic [38:0] got, want;
    logic [31:0] held;
    int cyc;
    int bad = 0;
    i_wb_ready = 1'b0;
    issue(1'b0, 1'b0, 3'b000, 32'hA5A5_0F0F, 32'd0, 5'd18, 32'hA5A5_0F0F, 1'b0, 1'b0);
    collect(got, want, cyc);
    n_vec++; if (got !== want) begin n_err++; $display("FAIL stall_result got %h required %h", got, want); end
    held = o_result;
    for (int k = 0; k < 3; k++) begin
      if (o_valid !== 1'b1 || o_result !== held || o_ready !== 1'b0) bad++;
      if (k < 2) @(negedge clk);
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL stall_hold got %0d unstable cycles required 0", bad); end
    i_wb_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_err++; $display("FAIL stall_release got v=%b rdy=%b required 0 1", o_valid, o_ready); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    ram_mode = 2;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'd0, 5'd19, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    n_vec++; if (o_mem_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_access got %b required 1", o_mem_ready); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (o_mem_ready !== 1'b0 || o_valid !== 1'b0) begin n_err++; $display("FAIL mid_async got mr=%b v=%b required 0 0", o_mem_ready, o_valid); end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    n_vec++; if (seen !== 0 || o_ready !== 1'b1) begin n_err++; $display("FAIL mid_no_result got %0d valid cycles rdy=%b required 0 1", seen, o_ready); end
    ram_mode = 0;
  endtask

  task automatic test_back_to_back();
    logic [38:0] got, want;
    int cyc;
    logic        ld  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b000, 3'b111};
    logic [31:0] adr [4] = '{32'h55AA_0001, 32'h0000_1003, 32'h0000_1002, 32'h0000_0000};
    logic [31:0] res [4] = '{32'h55AA_0001, 32'h0000_00A1, 32'hFFFF_FFB2, 32'h0000_0000};
    ram_mode = 0; ram_lat = 1; ram_word = 32'hA1B2_C3D4;
    for (int k = 0; k < 4; k++) begin
      issue(ld[k], 1'b0, f3[k], adr[k], 32'd0, 5'(20 + k), res[k], 1'b0, 1'b0);
      collect(got, want, cyc);
      n_vec++; if (got !== want) begin n_err++; $display("FAIL b2b_%0d got %h required %h", k, got, want); end
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_illegal_passthrough();
    test_mem_error();
    test_timeout();
    test_wb_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
